// File: rtl/dmem_pkg.sv
// dmem_pkg: shared funct3 size codes, byte-strobe helpers and requester IDs for the data-memory arbiter.
package dmem_pkg;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;
  typedef enum logic {REQ_CORE = 1'b0, REQ_DMA = 1'b1} req_id_e;
  function automatic logic [3:0] size_strb(input logic [2:0] size, input logic [1:0] off);
    return size[1] ? STRB_W : size[0] ? STRB_H << off : STRB_B << off;
  endfunction
  function automatic logic size_err(input logic [2:0] size, input logic [1:0] off);
    return size[1:0] == 2'b11 || size[2:1] == 2'b11 || (size[1] && off != 2'b00) || (size[0] && off[0]);
  endfunction
endpackage

// File: rtl/dmem_load_align.sv
// dmem_load_align: shifts the addressed bytes of a memory word down and sign/zero-extends them.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  off_i,
  input  logic [2:0]  size_i,
  output logic [31:0] data_o
);
  logic [31:0] sh;
  assign sh = word_i >> {off_i, 3'b000};
  always_comb data_o = size_i[1] ? word_i
                     : size_i[0] ? {{16{sh[15] & ~size_i[2]}}, sh[15:0]}
                     : {{24{sh[7] & ~size_i[2]}}, sh[7:0]};
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin core/DMA arbiter onto a single-port byte-strobed data memory with one-cycle load response.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 12
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_c_valid,
  output logic                       o_c_ready,
  input  logic                       i_c_write,
  input  logic [DMEM_ADDR_WIDTH-1:0] i_c_addr,
  input  logic [2:0]                 i_c_size,
  input  logic [31:0]                i_c_wdata,
  output logic                       o_c_rvalid,
  output logic [31:0]                o_c_rdata,
  output logic                       o_c_err,
  input  logic                       i_d_valid,
  output logic                       o_d_ready,
  input  logic                       i_d_write,
  input  logic [DMEM_ADDR_WIDTH-1:0] i_d_addr,
  input  logic [2:0]                 i_d_size,
  input  logic [31:0]                i_d_wdata,
  output logic                       o_d_rvalid,
  output logic [31:0]                o_d_rdata,
  output logic                       o_d_err,
  output logic [DMEM_ADDR_WIDTH-1:0] o_mem_addr,
  output logic                       o_mem_read,
  output logic                       o_mem_write,
  output logic [3:0]                 o_mem_size,
  output logic [31:0]                o_mem_din,
  input  logic [31:0]                i_mem_dout
);
  req_id_e last_q, last_d, own_q, own_d;
  logic rv_q, rv_d, err_q, err_d;
  logic [1:0] off_q;
  logic [2:0] size_q;
  logic gnt_any, gnt_dma, sel_write, sel_err;
  logic [DMEM_ADDR_WIDTH-1:0] sel_addr;
  logic [2:0] sel_size;
  logic [31:0] sel_wdata, ld_data;
  // Grants are gated by reset so nothing is accepted while i_rst_n is low.
  assign gnt_any   = i_rst_n && (i_c_valid || i_d_valid);
  assign gnt_dma   = i_d_valid && (!i_c_valid || last_q == REQ_CORE);
  assign o_c_ready = gnt_any && !gnt_dma;
  assign o_d_ready = gnt_any && gnt_dma;
  assign sel_write = gnt_dma ? i_d_write : i_c_write;
  assign sel_addr  = gnt_dma ? i_d_addr  : i_c_addr;
  assign sel_size  = gnt_dma ? i_d_size  : i_c_size;
  assign sel_wdata = gnt_dma ? i_d_wdata : i_c_wdata;
  assign sel_err   = size_err(sel_size, sel_addr[1:0]);
  assign o_mem_addr  = {sel_addr[DMEM_ADDR_WIDTH-1:2], 2'b00};
  assign o_mem_read  = gnt_any && !sel_write && !sel_err;
  assign o_mem_write = gnt_any && sel_write && !sel_err;
  assign o_mem_size  = (o_mem_read || o_mem_write) ? size_strb(sel_size, sel_addr[1:0]) : 4'b0000;
  assign o_mem_din   = sel_size[1] ? sel_wdata : sel_size[0] ? {2{sel_wdata[15:0]}} : {4{sel_wdata[7:0]}};
  always_comb begin
    last_d = gnt_any ? (gnt_dma ? REQ_DMA : REQ_CORE) : last_q;
    own_d  = gnt_dma ? REQ_DMA : REQ_CORE;
    rv_d   = o_mem_read;
    err_d  = gnt_any && sel_err;
  end
  // Pointer resets to "DMA last" so the core wins the first contested cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      last_q <= REQ_DMA;
      own_q  <= REQ_CORE;
      rv_q   <= 1'b0;
      err_q  <= 1'b0;
      off_q  <= 2'b00;
      size_q <= 3'b000;
    end else begin
      last_q <= last_d;
      own_q  <= own_d;
      rv_q   <= rv_d;
      err_q  <= err_d;
      off_q  <= sel_addr[1:0];
      size_q <= sel_size;
    end
  end
  dmem_load_align u_align (
    .word_i (i_mem_dout),
    .off_i  (off_q),
    .size_i (size_q),
    .data_o (ld_data)
  );
  assign o_c_rvalid = rv_q && own_q == REQ_CORE;
  assign o_d_rvalid = rv_q && own_q == REQ_DMA;
  assign o_c_err    = err_q && own_q == REQ_CORE;
  assign o_d_err    = err_q && own_q == REQ_DMA;
  assign o_c_rdata  = o_c_rvalid ? ld_data : 32'h0;
  assign o_d_rdata  = o_d_rvalid ? ld_data : 32'h0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed table-driven and sequence checks of dmem_arbiter against a behavioural memory.
module tb_dmem_arbiter;
  import dmem_pkg::*;
  logic i_clk, i_rst_n;
  logic i_c_valid, o_c_ready, i_c_write, o_c_rvalid, o_c_err;
  logic [11:0] i_c_addr;
  logic [2:0] i_c_size;
  logic [31:0] i_c_wdata, o_c_rdata;
  logic i_d_valid, o_d_ready, i_d_write, o_d_rvalid, o_d_err;
  logic [11:0] i_d_addr;
  logic [2:0] i_d_size;
  logic [31:0] i_d_wdata, o_d_rdata;
  logic [11:0] o_mem_addr;
  logic o_mem_read, o_mem_write;
  logic [3:0] o_mem_size;
  logic [31:0] o_mem_din, i_mem_dout;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] mem [0:1023];

  dmem_arbiter #(.DMEM_ADDR_WIDTH(12)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_c_valid(i_c_valid), .o_c_ready(o_c_ready), .i_c_write(i_c_write), .i_c_addr(i_c_addr),
    .i_c_size(i_c_size), .i_c_wdata(i_c_wdata), .o_c_rvalid(o_c_rvalid), .o_c_rdata(o_c_rdata), .o_c_err(o_c_err),
    .i_d_valid(i_d_valid), .o_d_ready(o_d_ready), .i_d_write(i_d_write), .i_d_addr(i_d_addr),
    .i_d_size(i_d_size), .i_d_wdata(i_d_wdata), .o_d_rvalid(o_d_rvalid), .o_d_rdata(o_d_rdata), .o_d_err(o_d_err),
    .o_mem_addr(o_mem_addr), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
    .o_mem_size(o_mem_size), .o_mem_din(o_mem_din), .i_mem_dout(i_mem_dout)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Behavioural memory: initialised while in reset, byte-strobed writes, one-cycle read latency.
  always @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int w = 0; w < 1024; w++) mem[w] <= 32'h0;
      mem[0] <= 32'h11223344;
      mem[1] <= 32'h55667788;
    end else begin
      if (o_mem_write)
        for (int k = 0; k < 4; k++)
          if (o_mem_size[k]) mem[o_mem_addr[11:2]][8*k +: 8] <= o_mem_din[8*k +: 8];
      if (o_mem_read) i_mem_dout <= mem[o_mem_addr[11:2]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_c(input logic v, input logic w, input logic [11:0] a, input logic [2:0] s, input logic [31:0] d);
    i_c_valid = v; i_c_write = w; i_c_addr = a; i_c_size = s; i_c_wdata = d;
  endtask

  task automatic set_d(input logic v, input logic w, input logic [11:0] a, input logic [2:0] s, input logic [31:0] d);
    i_d_valid = v; i_d_write = w; i_d_addr = a; i_d_size = s; i_d_wdata = d;
  endtask

  typedef struct {
    logic        wr;
    logic [11:0] addr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  vec_t tbl [16];
  logic exp_c [4];
  logic [31:0] mask, lanes;

  initial begin
    tbl[0]  = '{1'b1, 12'h005, F3_B,   32'h000000AB, 4'b0010, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 12'h005, F3_B,   32'h0,        4'b0010, 1'b0, 32'hFFFFFFAB};
    tbl[2]  = '{1'b0, 12'h005, F3_BU,  32'h0,        4'b0010, 1'b0, 32'h000000AB};
    tbl[3]  = '{1'b1, 12'h020, F3_W,   32'h80017F02, 4'b1111, 1'b0, 32'h0};
    tbl[4]  = '{1'b0, 12'h020, F3_H,   32'h0,        4'b0011, 1'b0, 32'h00007F02};
    tbl[5]  = '{1'b0, 12'h022, F3_H,   32'h0,        4'b1100, 1'b0, 32'hFFFF8001};
    tbl[6]  = '{1'b0, 12'h022, F3_HU,  32'h0,        4'b1100, 1'b0, 32'h00008001};
    tbl[7]  = '{1'b0, 12'h023, F3_B,   32'h0,        4'b1000, 1'b0, 32'hFFFFFF80};
    tbl[8]  = '{1'b0, 12'h020, F3_W,   32'h0,        4'b1111, 1'b0, 32'h80017F02};
    tbl[9]  = '{1'b1, 12'h026, F3_H,   32'h00001234, 4'b1100, 1'b0, 32'h0};
    tbl[10] = '{1'b0, 12'h024, F3_W,   32'h0,        4'b1111, 1'b0, 32'h12340000};
    tbl[11] = '{1'b0, 12'h002, F3_W,   32'h0,        4'b0000, 1'b1, 32'h0};
    tbl[12] = '{1'b0, 12'h020, 3'b011, 32'h0,        4'b0000, 1'b1, 32'h0};
    tbl[13] = '{1'b1, 12'h021, F3_H,   32'h0000BEEF, 4'b0000, 1'b1, 32'h0};
    tbl[14] = '{1'b0, 12'h025, F3_HU,  32'h0,        4'b0000, 1'b1, 32'h0};
    tbl[15] = '{1'b0, 12'h027, F3_BU,  32'h0,        4'b1000, 1'b0, 32'h00000012};
    exp_c = '{1'b1, 1'b0, 1'b1, 1'b0};
    i_rst_n = 1'b0;
    set_c(1'b1, 1'b0, 12'h000, F3_W, 32'h0);
    set_d(1'b1, 1'b0, 12'h004, F3_W, 32'h0);
    #1;
    chk("rst c_ready", o_c_ready, 0);
    chk("rst d_ready", o_d_ready, 0);
    chk("rst mem_read", o_mem_read, 0);
    chk("rst mem_write", o_mem_write, 0);
    chk("rst mem_size", o_mem_size, 0);
    chk("rst c_rvalid", o_c_rvalid, 0);
    chk("rst c_rdata", o_c_rdata, 0);
    chk("rst d_err", o_d_err, 0);
    repeat (3) step();
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr%0d c_ready", k), o_c_ready, exp_c[k]);
      chk($sformatf("rr%0d d_ready", k), o_d_ready, !exp_c[k]);
      chk($sformatf("rr%0d c_rvalid", k), o_c_rvalid, k > 0 && exp_c[(k+3)%4]);
      chk($sformatf("rr%0d d_rvalid", k), o_d_rvalid, k > 0 && !exp_c[(k+3)%4]);
      chk($sformatf("rr%0d c_rdata", k), o_c_rdata, (k > 0 && exp_c[(k+3)%4]) ? 32'h11223344 : 32'h0);
      chk($sformatf("rr%0d d_rdata", k), o_d_rdata, (k > 0 && !exp_c[(k+3)%4]) ? 32'h55667788 : 32'h0);
      step();
    end
    set_c(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    set_d(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("rr last d_rvalid", o_d_rvalid, 1);
    chk("rr last d_rdata", o_d_rdata, 32'h55667788);
    chk("rr last c_rvalid", o_c_rvalid, 0);
    chk("idle mem_read", o_mem_read, 0);
    step();
    set_c(1'b1, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("b2b first c_ready", o_c_ready, 1);
    step();
    set_c(1'b1, 1'b0, 12'h004, F3_W, 32'h0);
    #1;
    chk("b2b second c_ready", o_c_ready, 1);
    chk("b2b rv1", o_c_rvalid, 1);
    chk("b2b data1", o_c_rdata, 32'h11223344);
    step();
    set_c(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("b2b rv2", o_c_rvalid, 1);
    chk("b2b data2", o_c_rdata, 32'h55667788);
    step();
    chk("b2b rv end", o_c_rvalid, 0);
    chk("b2b rdata end", o_c_rdata, 0);
    set_d(1'b1, 1'b0, 12'h003, F3_H, 32'h0);
    #1;
    chk("derr d_ready", o_d_ready, 1);
    chk("derr mem_read", o_mem_read, 0);
    chk("derr mem_size", o_mem_size, 0);
    step();
    set_d(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("derr d_err", o_d_err, 1);
    chk("derr c_err", o_c_err, 0);
    chk("derr d_rvalid", o_d_rvalid, 0);
    step();
    chk("derr pulse end", o_d_err, 0);
    for (int i = 0; i < 16; i++) begin
      step();
      set_c(1'b1, tbl[i].wr, tbl[i].addr, tbl[i].size, tbl[i].wdata);
      #1;
      for (int k = 0; k < 4; k++) mask[8*k +: 8] = {8{tbl[i].strb[k]}};
      lanes = tbl[i].wdata << (8 * tbl[i].addr[1:0]);
      chk($sformatf("v%0d prev rvalid", i), o_c_rvalid, 0);
      chk($sformatf("v%0d prev err", i), o_c_err, 0);
      chk($sformatf("v%0d c_ready", i), o_c_ready, 1);
      chk($sformatf("v%0d mem_write", i), o_mem_write, tbl[i].wr && !tbl[i].err);
      chk($sformatf("v%0d mem_read", i), o_mem_read, !tbl[i].wr && !tbl[i].err);
      chk($sformatf("v%0d mem_size", i), o_mem_size, tbl[i].strb);
      if (!tbl[i].err) chk($sformatf("v%0d mem_addr", i), o_mem_addr, tbl[i].addr & 12'hFFC);
      if (tbl[i].wr && !tbl[i].err) chk($sformatf("v%0d mem_din", i), o_mem_din & mask, lanes & mask);
      step();
      set_c(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
      #1;
      chk($sformatf("v%0d c_rvalid", i), o_c_rvalid, !tbl[i].wr && !tbl[i].err);
      chk($sformatf("v%0d c_err", i), o_c_err, tbl[i].err);
      chk($sformatf("v%0d c_rdata", i), o_c_rdata, tbl[i].rdata);
      chk($sformatf("v%0d d_rvalid", i), o_d_rvalid, 0);
    end
    step();
    set_c(1'b1, 1'b0, 12'h030, F3_W, 32'h0);
    set_d(1'b1, 1'b1, 12'h030, F3_W, 32'hCAFEF00D);
    #1;
    chk("same d_ready", o_d_ready, 1);
    chk("same c_ready", o_c_ready, 0);
    chk("same mem_write", o_mem_write, 1);
    step();
    set_d(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("same c_ready2", o_c_ready, 1);
    chk("same mem_read", o_mem_read, 1);
    step();
    set_c(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("same c_rvalid", o_c_rvalid, 1);
    chk("same c_rdata", o_c_rdata, 32'hCAFEF00D);
    step();
    set_c(1'b1, 1'b0, 12'h000, F3_W, 32'h0);
    #1;
    chk("prerst c_ready", o_c_ready, 1);
    step();
    i_rst_n = 1'b0;
    set_d(1'b1, 1'b0, 12'h004, F3_W, 32'h0);
    #1;
    chk("midrst c_rvalid", o_c_rvalid, 0);
    chk("midrst c_rdata", o_c_rdata, 0);
    chk("midrst c_ready", o_c_ready, 0);
    chk("midrst d_ready", o_d_ready, 0);
    chk("midrst mem_read", o_mem_read, 0);
    chk("midrst mem_size", o_mem_size, 0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    #1;
    chk("postrst c_ready", o_c_ready, 1);
    chk("postrst d_ready", o_d_ready, 0);
    chk("postrst c_rvalid", o_c_rvalid, 0);
    step();
    set_c(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    set_d(1'b0, 1'b0, 12'h000, F3_W, 32'h0);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
